// File: rtl/jtdsp16_prog_loader.sv
// jtdsp16_prog_loader: streams download bytes into the DSP16 program ROM, holding the DSP in reset until the image is loaded.
module jtdsp16_prog_loader #(
  parameter int LEN  = 8192,
  parameter int HOLD = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  dl_data_i,
  input  logic        dl_valid_i,
  output logic        dl_ready_o,
  output logic [12:0] prog_addr_o,
  output logic [7:0]  prog_data_o,
  output logic        prog_we_o,
  output logic        dsp_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] checksum_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;
  localparam logic [12:0] LAST  = 13'(LEN - 1);
  localparam logic [7:0]  HLAST = 8'(HOLD - 1);
  state_t      state_q;
  logic [12:0] cnt_q, prog_addr_q;
  logic [7:0]  hold_q, prog_data_q;
  logic [15:0] checksum_q;
  logic        prog_we_q, dsp_rst_q, busy_q, done_q, acc;
  assign dl_ready_o  = (state_q == S_LOAD) & ~abort_i;
  assign acc         = dl_valid_i & dl_ready_o;
  assign prog_addr_o = prog_addr_q;
  assign prog_data_o = prog_data_q;
  assign prog_we_o   = prog_we_q;
  assign dsp_rst_o   = dsp_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign checksum_o  = checksum_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      checksum_q  <= '0;
      prog_we_q   <= 1'b0;
      dsp_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      prog_we_q <= acc;
      if (acc) begin
        prog_addr_q <= cnt_q;
        prog_data_q <= dl_data_i;
        checksum_q  <= checksum_q + {8'd0, dl_data_i};
        cnt_q       <= cnt_q + 13'd1;
      end
      case (state_q)
        S_IDLE, S_DONE: if (start_i) begin
          state_q    <= S_LOAD;
          cnt_q      <= '0;
          checksum_q <= '0;
          done_q     <= 1'b0;
          dsp_rst_q  <= 1'b1;
          busy_q     <= 1'b1;
        end
        S_LOAD: if (abort_i) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else if (acc && cnt_q == LAST) begin
          state_q <= S_HOLD;
          hold_q  <= '0;
        end
        S_HOLD: if (abort_i) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else if (hold_q == HLAST) begin
          state_q   <= S_DONE;
          dsp_rst_q <= 1'b0;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end else hold_q <= hold_q + 8'd1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// tb_jtdsp16_prog_loader: random handshake loads checked cycle by cycle against a byte-stream model, plus a tiny LEN=2 image.
module tb_jtdsp16_prog_loader;
  localparam int LEN = 8192, HOLD = 16, TMO = 60000;
  logic clk = 0, rst = 1, start = 0, abort = 0, dl_valid = 0;
  logic [7:0] dl_data = 0;
  logic dl_ready, prog_we, dsp_rst, busy, done;
  logic [12:0] prog_addr;
  logic [7:0] prog_data;
  logic [15:0] checksum;
  logic start2 = 0, valid2 = 0, zero = 0;
  logic [7:0] data2 = 0;
  logic ready2, we2, dsp_rst2, busy2, done2;
  logic [12:0] addr2;
  logic [7:0] pdata2;
  logic [15:0] csum2;
  int checks = 0, errors = 0, wr_cnt = 0;
  logic [7:0] img [LEN];
  logic [7:0] rom [LEN];
  bit m_busy, m_load, m_we, m_done, m_dsprst;
  int m_n, m_sum, m_left, m_addr, m_data;

  always #5 clk = ~clk;

  jtdsp16_prog_loader #(.LEN(LEN), .HOLD(HOLD)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .dl_data_i(dl_data),
    .dl_valid_i(dl_valid), .dl_ready_o(dl_ready), .prog_addr_o(prog_addr), .prog_data_o(prog_data),
    .prog_we_o(prog_we), .dsp_rst_o(dsp_rst), .busy_o(busy), .done_o(done), .checksum_o(checksum));

  jtdsp16_prog_loader #(.LEN(2), .HOLD(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(zero), .dl_data_i(data2),
    .dl_valid_i(valid2), .dl_ready_o(ready2), .prog_addr_o(addr2), .prog_data_o(pdata2),
    .prog_we_o(we2), .dsp_rst_o(dsp_rst2), .busy_o(busy2), .done_o(done2), .checksum_o(csum2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: count accepted bytes; after the LEN-th one, wait HOLD edges then release the DSP.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_load = 0; m_we = 0; m_done = 0; m_dsprst = 1;
      m_n = 0; m_sum = 0; m_left = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = m_load && !abort && dl_valid;
      if (m_we) begin
        m_addr = m_n; m_data = dl_data; m_sum = (m_sum + dl_data) % 65536; m_n++;
      end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_load = 1; m_n = 0; m_sum = 0; m_done = 0; m_dsprst = 1;
        end
      end else if (abort) begin
        m_busy = 0; m_load = 0;
      end else if (m_load) begin
        if (m_n == LEN) begin m_load = 0; m_left = HOLD; end
      end else begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; m_dsprst = 0; end
      end
    end
  end

  always @(negedge clk) begin
    chk("we", prog_we, m_we);
    chk("addr", prog_addr, m_addr);
    chk("data", prog_data, m_data);
    chk("csum", checksum, m_sum);
    chk("dsp_rst", dsp_rst, m_dsprst);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("ready", dl_ready, m_load && !abort);
    if (prog_we) begin
      rom[prog_addr] = prog_data;
      wr_cnt++;
    end
  end

  task automatic run_load(input int pv, input int ps, input int abort_at, input int rst_at);
    int cyc = 0, bad = 0, sum = 0;
    for (int i = 0; i < LEN; i++) rom[i] = ~img[i];
    wr_cnt = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (m_load && cyc < TMO) begin
      if (m_n == abort_at) begin
        abort = 1; dl_valid = 1; dl_data = img[m_n];
        #1 chk("abort_ready", dl_ready, 0);
        @(posedge clk); #1;
        abort = 0; dl_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", wr_cnt, abort_at);
        chk("abort_done", done, 0);
        chk("abort_dsp_rst", dsp_rst, 1);
        chk("abort_busy", busy, 0);
        return;
      end
      if (m_n == rst_at) begin
        dl_valid = 0;
        @(negedge clk); #1;
        rst = 1;
        #1;
        chk("rst_we", prog_we, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_csum", checksum, 0);
        chk("rst_dsp_rst", dsp_rst, 1);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        dl_valid = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_writes", wr_cnt, rst_at);
        dl_valid = 0;
        return;
      end
      dl_valid = ($urandom_range(99) < pv);
      dl_data = img[m_n];
      start = ($urandom_range(99) < ps);
      @(posedge clk); #1;
      start = 0; cyc++;
    end
    dl_valid = 0;
    while (m_busy && cyc < TMO) begin
      start = ($urandom_range(99) < ps);
      @(posedge clk); #1;
      start = 0; cyc++;
    end
    chk("timeout", cyc < TMO, 1);
    chk("end_done", done, 1);
    chk("end_dsp_rst", dsp_rst, 0);
    chk("end_writes", wr_cnt, LEN);
    for (int i = 0; i < LEN; i++) begin
      if (rom[i] !== img[i]) bad++;
      sum += img[i];
    end
    chk("rom_bad", bad, 0);
    chk("end_csum", checksum, sum % 65536);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("r_we", prog_we, 0);
    chk("r_addr", prog_addr, 0);
    chk("r_data", prog_data, 0);
    chk("r_dsp_rst", dsp_rst, 1);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_csum", checksum, 0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < LEN; i++) img[i] = 8'(i);
    run_load(100, 0, -1, -1);
    chk("csum_f000", checksum, 16'hF000);
    for (int i = 0; i < LEN; i++) img[i] = 8'($urandom);
    run_load(60, 5, -1, -1);
    run_load(100, 0, 100, -1);
    run_load(80, 0, -1, 50);
    for (int i = 0; i < LEN; i++) img[i] = 8'(i);
    run_load(100, 0, -1, -1);
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0; valid2 = 1; data2 = 8'h34;
    @(posedge clk); #1;
    chk("s_we0", we2, 1);
    chk("s_addr0", addr2, 0);
    chk("s_data0", pdata2, 8'h34);
    chk("s_csum0", csum2, 16'h0034);
    data2 = 8'h12;
    @(posedge clk); #1;
    valid2 = 0;
    chk("s_we1", we2, 1);
    chk("s_addr1", addr2, 1);
    chk("s_data1", pdata2, 8'h12);
    chk("s_csum1", csum2, 16'h0046);
    chk("s_ready_hold", ready2, 0);
    chk("s_done_early", done2, 0);
    @(posedge clk); #1;
    chk("s_done", done2, 1);
    chk("s_dsp_rst", dsp_rst2, 0);
    chk("s_busy", busy2, 0);
    chk("s_we_off", we2, 0);
    chk("s_csum_hold", csum2, 16'h0046);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
